// File: rtl/peak_capture_serializer_pkg.sv
// Shared constants, FSM state type and frame-length helper for the
// peak-capture serialiser.
package peak_capture_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    typedef enum logic [1:0] {
        IDLE,
        HEADER,
        PAYLOAD,
        CHECKSUM
    } state_t;

    // Sync byte + four bytes per channel + checksum byte.
    function automatic int frame_len(input int num_ch);
        return 2 + 4 * num_ch;
    endfunction

endpackage

// File: rtl/peak_capture_serializer_if.sv
// Byte-stream handshake towards the UART transmitter.
interface peak_capture_serializer_if;

    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);

endinterface

// File: rtl/peak_channel.sv
// Live peak-hold for one ADC channel: keeps the running maximum and the
// sample index at which it first occurred.
module peak_channel #(
    parameter int SAMPLE_W = 10,
    parameter int IDX_W    = 16
) (
    input  logic                clk,
    input  logic                reset_b,
    input  logic [SAMPLE_W-1:0] sample,
    input  logic                sample_valid,
    input  logic                clear,
    input  logic [IDX_W-1:0]    sample_idx,
    output logic [SAMPLE_W-1:0] peak,
    output logic [IDX_W-1:0]    peak_idx
);

    // A clear in the same cycle means the sample competes against zero.
    logic [SAMPLE_W-1:0] base_peak;

    assign base_peak = clear ? '0 : peak;

    // Take a strictly larger sample (ties keep the first index), else honour clear.
    always_ff @(posedge clk or negedge reset_b) begin
        // NOTE: state registers use non-blocking assignment so every flop
        // samples pre-edge values regardless of block ordering.
        if (!reset_b) begin
            peak     <= '0;
            peak_idx <= '0;
        end else if (sample_valid && (sample > base_peak)) begin
            peak     <= sample;
            peak_idx <= sample_idx;
        end else if (clear) begin
            peak     <= '0;
            peak_idx <= '0;
        end
    end

endmodule

// File: rtl/peak_capture_serializer.sv
// Per-channel peak-hold with snapshot-and-stream readout: on dump_req the
// live peaks are frozen into shadows and sent as a checksummed byte frame.
module peak_capture_serializer
    import peak_capture_pkg::*;
#(
    parameter int NUM_CH   = 4,
    parameter int SAMPLE_W = 10,
    parameter int IDX_W    = 16
) (
    input  logic                       clk,
    input  logic                       reset_b,
    input  logic [NUM_CH*SAMPLE_W-1:0] adc_data,
    input  logic                       sample_valid,
    input  logic                       peak_clear,
    input  logic                       dump_req,
    peak_capture_serializer_if.master  tx,
    output logic                       busy,
    output logic                       dump_dropped
);

    localparam int               PAY_LEN   = 4 * NUM_CH;
    localparam logic [5:0]       LAST_BYTE = 6'(PAY_LEN - 1);
    localparam logic [IDX_W-1:0] IDX_MAX   = '1;

    state_t     state, state_nxt;
    logic [5:0] byte_cnt, byte_cnt_nxt;
    logic [7:0] csum;
    logic [7:0] tx_byte;
    logic       start, accept, live_clear;

    logic [IDX_W-1:0] idx_cnt, sample_idx;
    logic [15:0]      sel_peak, sel_idx;

    logic [NUM_CH-1:0][SAMPLE_W-1:0] live_peak;
    logic [NUM_CH-1:0][IDX_W-1:0]    live_idx;
    logic [NUM_CH-1:0][15:0]         shadow_peak, shadow_idx;

    assign start      = dump_req && (state == IDLE);
    assign accept     = tx.tx_valid && tx.tx_ready;
    assign live_clear = peak_clear || start;
    assign sample_idx = live_clear ? '0 : idx_cnt;

    // Sample index counter: saturating, restarts at 0 (or 1 if a sample lands) on clear.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            idx_cnt <= '0;
        end else if (live_clear) begin
            idx_cnt <= sample_valid ? IDX_W'(1) : '0;
        end else if (sample_valid && (idx_cnt != IDX_MAX)) begin
            idx_cnt <= idx_cnt + 1'b1;
        end
    end

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        peak_channel #(
            .SAMPLE_W (SAMPLE_W),
            .IDX_W    (IDX_W)
        ) u_peak_channel (
            .clk          (clk),
            .reset_b      (reset_b),
            .sample       (adc_data[k*SAMPLE_W +: SAMPLE_W]),
            .sample_valid (sample_valid),
            .clear        (live_clear),
            .sample_idx   (sample_idx),
            .peak         (live_peak[k]),
            .peak_idx     (live_idx[k])
        );
    end

    // Shadow snapshot of all channels, zero-extended to 16 bits, taken when a frame starts.
    always_ff @(posedge clk or negedge reset_b) begin
        // NOTE: the shadow bank is reset explicitly because a dump right after
        // reset must report zeros, so it cannot be left as an unreset RAM.
        if (!reset_b) begin
            shadow_peak <= '0;
            shadow_idx  <= '0;
        end else if (start) begin
            for (int k = 0; k < NUM_CH; k++) begin
                shadow_peak[k] <= 16'(live_peak[k]);
                shadow_idx[k]  <= 16'(live_idx[k]);
            end
        end
    end

    // FSM state and payload byte counter registers.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state    <= IDLE;
            byte_cnt <= '0;
        end else begin
            state    <= state_nxt;
            byte_cnt <= byte_cnt_nxt;
        end
    end

    // Next-state logic: each state advances only on an accepted byte.
    always_comb begin
        // NOTE: defaults first so every path assigns every output and no
        // latch is inferred.
        state_nxt    = state;
        byte_cnt_nxt = byte_cnt;
        case (state)
            IDLE: begin
                if (dump_req) begin
                    state_nxt    = HEADER;
                    byte_cnt_nxt = '0;
                end
            end
            HEADER: begin
                if (accept) state_nxt = PAYLOAD;
            end
            PAYLOAD: begin
                if (accept) begin
                    if (byte_cnt == LAST_BYTE) state_nxt = CHECKSUM;
                    else                       byte_cnt_nxt = byte_cnt + 6'd1;
                end
            end
            CHECKSUM: begin
                if (accept) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Running XOR of every byte handed over, zeroed at the start of each frame.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            csum <= '0;
        end else if (start) begin
            csum <= '0;
        end else if (accept && (state != CHECKSUM)) begin
            csum <= csum ^ tx_byte;
        end
    end

    // Byte mux: built only from registered state, so it holds while the sink stalls.
    always_comb begin
        sel_peak = '0;
        sel_idx  = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (byte_cnt[5:2] == 4'(k)) begin
                sel_peak = shadow_peak[k];
                sel_idx  = shadow_idx[k];
            end
        end
        tx_byte = 8'h00;
        case (state)
            HEADER:   tx_byte = SYNC_BYTE;
            PAYLOAD: begin
                case (byte_cnt[1:0])
                    2'd0:    tx_byte = sel_peak[15:8];
                    2'd1:    tx_byte = sel_peak[7:0];
                    2'd2:    tx_byte = sel_idx[15:8];
                    default: tx_byte = sel_idx[7:0];
                endcase
            end
            CHECKSUM: tx_byte = csum;
            default:  tx_byte = 8'h00;
        endcase
    end

    assign tx.tx_data    = tx_byte;
    assign tx.tx_valid   = (state != IDLE);
    assign busy          = (state != IDLE);
    assign dump_dropped  = dump_req && (state != IDLE);

endmodule
